instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues 8-byte local-store reads and queues {word1, word2}
// pairs in a 2-entry FIFO, with branch redirect, squash of in-flight reads and odd-word entry.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h4020_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [31:0] instruction1_IF,
    output logic [31:0] instruction2_IF,
    output logic        valid_IF
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned PAIR_W  = 64;
    localparam int unsigned COUNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    fetch_pc_q;
    logic [ADDR_W-1:0]    req_addr_q;
    logic                 odd_pending_q;
    logic [PAIR_W-1:0]    fifo_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [COUNT_W-1:0]   count_q;

    logic                 issue;
    logic                 push;
    logic                 pop;
    logic [PAIR_W-1:0]    push_data;
    logic [PAIR_W-1:0]    head;

    // Next-state and request decode; a branch always wins over issuing or accepting data
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_addr = req_addr_q;
        issue    = 1'b0;
        push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_addr = fetch_pc_q;
                if ((count_q < COUNT_W'(2)) && !branch_taken) begin
                    mem_req = 1'b1;
                    issue   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    push    = !branch_taken;
                    state_d = S_IDLE;
                end else if (branch_taken) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!reset) begin
            mem_req = 1'b0;
            issue   = 1'b0;
            push    = 1'b0;
        end
    end

    assign pop       = (count_q != COUNT_W'(0)) && !stall && !branch_taken;
    assign push_data = odd_pending_q ? {NOP_WORD, mem_rdata[31:0]} : mem_rdata;
    assign head      = fifo_q[rd_ptr_q];

    assign valid_IF        = (count_q != COUNT_W'(0));
    assign instruction1_IF = valid_IF ? head[63:32] : 32'h0;
    assign instruction2_IF = valid_IF ? head[31:0]  : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC, outstanding address, odd-entry flag and pair FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            req_addr_q    <= RESET_PC;
            odd_pending_q <= 1'b0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= '0;
        end else begin
            if (issue) begin
                req_addr_q <= fetch_pc_q;
            end
            if (branch_taken) begin
                fetch_pc_q    <= {branch_target[31:3], 3'b000};
                odd_pending_q <= branch_target[2];
                wr_ptr_q      <= 1'b0;
                rd_ptr_q      <= 1'b0;
                count_q       <= '0;
            end else begin
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + ADDR_W'(8);
                end
                if (push) begin
                    fifo_q[wr_ptr_q] <= push_data;
                    wr_ptr_q         <= ~wr_ptr_q;
                    odd_pending_q    <= 1'b0;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + COUNT_W'(1);
                    2'b01:   count_q <= count_q - COUNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory responder answers reads with {addr, addr+4},
// and the expected pair stream is derived from the program-order fetch rules.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h4020_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [31:0] instruction1_IF;
    logic [31:0] instruction2_IF;
    logic        valid_IF;

    instr_fetch #(.RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instruction1_IF(instruction1_IF),
        .instruction2_IF(instruction2_IF),
        .valid_IF       (valid_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pairs_seen = 0;
    int          first_ack_cyc = -1;
    int          first_valid_cyc = -1;
    int          lat_mode = 1;
    logic [63:0] exp_q[$];
    logic [31:0] issued_q[$];
    logic [31:0] gen_pc;
    logic        gen_odd;
    bit          pending = 0;
    bit          acking = 0;
    logic [31:0] paddr;
    int          wait_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Program-order model: one pair per 8-byte block; an odd entry point replaces word1 with NOP
    task automatic top_up();
        while (exp_q.size() < 16) begin
            if (gen_odd) exp_q.push_back({NOP, gen_pc + 32'd4});
            else         exp_q.push_back({gen_pc, gen_pc + 32'd4});
            gen_odd = 1'b0;
            gen_pc  = gen_pc + 32'd8;
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        exp_q.delete();
        gen_pc  = {t[31:3], 3'b000};
        gen_odd = t[2];
        top_up();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        top_up();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: one read at a time, checks request stability while outstanding
    initial forever begin
        @(posedge clk);
        #2;
        if (!reset) begin
            pending = 0;
            acking  = 0;
            mem_ack = 1'b0;
        end else begin
            if (acking) begin
                mem_ack = 1'b0;
                acking  = 0;
                pending = 0;
            end
            if (pending) begin
                chk("req_held", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, paddr});
                wait_left--;
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = {paddr, paddr + 32'd4};
                    acking    = 1;
                    if (first_ack_cyc < 0) first_ack_cyc = cyc;
                end
            end else if (mem_req) begin
                chk("addr_align", {61'd0, mem_addr[2:0]}, 64'd0);
                pending = 1;
                paddr   = mem_addr;
                issued_q.push_back(mem_addr);
                wait_left = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 3));
            end else if (lat_mode == 0 && $urandom_range(0, 7) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = {$urandom, $urandom};
                acking    = 1;
            end
        end
    end

    // Monitor: compares each accepted pair with the scoreboard and checks stall hold / bubbles
    initial begin
        logic [63:0] head, prev_head, exp;
        bit          prev_hold;
        prev_hold = 0;
        prev_head = '0;
        forever begin
            @(negedge clk);
            head = {instruction1_IF, instruction2_IF};
            if (!reset) begin
                prev_hold = 0;
            end else begin
                if (!valid_IF) chk("bubble_zero", head, 64'd0);
                if (prev_hold) begin
                    chk("stall_hold_valid", {63'd0, valid_IF}, 64'd1);
                    chk("stall_hold_pair", head, prev_head);
                end
                if (valid_IF && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (valid_IF && !stall && !branch_taken) begin
                    pairs_seen++;
                    if (exp_q.size() == 0) begin
                        chk("pair_unexpected", head, 64'hx);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("pair", head, exp);
                    end
                end
                prev_hold = valid_IF && stall && !branch_taken;
                prev_head = head;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        mem_ack       = 1'b0;
        mem_rdata     = 64'h0;
        redirect(RESET_PC);
        #1;
        chk("reset_req", {63'd0, mem_req}, 64'd0);
        chk("reset_valid", {63'd0, valid_IF}, 64'd0);
        chk("reset_instr", {instruction1_IF, instruction2_IF}, 64'd0);

        // Reset release, single-cycle memory, no stall
        repeat (2) tick();
        lat_mode = 1;
        issued_q.delete();
        first_ack_cyc   = -1;
        first_valid_cyc = -1;
        redirect(RESET_PC);
        reset = 1'b1;
        repeat (12) tick();
        chk("issue_count", {63'd0, issued_q.size() >= 3}, 64'd1);
        if (issued_q.size() >= 3) begin
            chk("addr0", {32'd0, issued_q[0]}, 64'h0);
            chk("addr1", {32'd0, issued_q[1]}, 64'h8);
            chk("addr2", {32'd0, issued_q[2]}, 64'h10);
        end
        chk("latency", 64'(first_valid_cyc - first_ack_cyc), 64'd1);

        // Long stall: FIFO fills and requests stop
        stall = 1'b1;
        repeat (6) tick();
        #1;
        chk("stall_full_noreq", {63'd0, mem_req}, 64'd0);
        chk("stall_full_valid", {63'd0, valid_IF}, 64'd1);
        tick();
        stall = 1'b0;
        repeat (8) tick();

        // Randomized stall, latency and redirects
        lat_mode = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 19) == 0);
            if (branch_taken) begin
                branch_target = $urandom & 32'h0000_0FFF;
                redirect(branch_target);
            end
        end
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        chk("random_progress", {63'd0, pairs_seen > 100}, 64'd1);

        // Asynchronous reset while a read is outstanding
        lat_mode = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            #2;
            found = pending && !acking;
        end
        chk("wait_found_rst", {63'd0, found}, 64'd1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_req", {63'd0, mem_req}, 64'd0);
        chk("async_rst_valid", {63'd0, valid_IF}, 64'd0);
        chk("async_rst_instr", {instruction1_IF, instruction2_IF}, 64'd0);
        repeat (2) tick();
        issued_q.delete();
        redirect(RESET_PC);
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_first_addr", {32'd0, (issued_q.size() > 0) ? issued_q[0] : 32'hFFFF_FFFF},
            {32'd0, RESET_PC});

        // Redirect to 0x100 while the read for 0x40 is outstanding
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            #2;
            found = pending && !acking && (issued_q.size() > 0) && (issued_q[$] == 32'h40);
        end
        chk("wait_found_40", {63'd0, found}, 64'd1);
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        redirect(32'h100);
        issued_q.delete();
        tick();
        branch_taken = 1'b0;
        repeat (10) tick();
        chk("branch_addr_100", {32'd0, (issued_q.size() > 0) ? issued_q[0] : 32'hFFFF_FFFF},
            64'h100);

        // Odd-word redirect
        lat_mode = 1;
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h10C;
        redirect(32'h10C);
        issued_q.delete();
        tick();
        branch_taken = 1'b0;
        repeat (8) tick();
        chk("branch_addr_108", {32'd0, (issued_q.size() > 0) ? issued_q[0] : 32'hFFFF_FFFF},
            64'h108);

        // Redirect coincident with the ack that would fill the FIFO
        lat_mode = 3;
        stall    = 1'b1;
        found    = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            #2;
            found = pending && !acking && (wait_left == 1) && valid_IF;
        end
        chk("wait_found_full", {63'd0, found}, 64'd1);
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        redirect(32'h200);
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        #1;
        chk("flush_bubble", {63'd0, valid_IF}, 64'd0);
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
